scene_sequencer: RTL
====================

Name: scene_sequencer

Overview:
- Top-level screen controller that decides which screen owns the VGA colour output: menu screen, playfield, or game-over screen.
- Sequences the transitions MENU -> START -> PLAY -> OVER -> (START | MENU).
- Holds the game logic in reset while it is not playing.
- Generates the frame-counted blink mask for the game-over text region, replacing free-running divider blinking.
- Every scene change and blink toggle takes effect only on a frame tick, so no frame tears.

Parameters:
- BLINK_FRAMES, 30, frames per blink half-period in OVER (1..255).
- OVER_FRAMES, 300, frames spent in OVER before auto-return to MENU (must be >= 2).

Ports:
- CLK  in  1  100 MHz system clock
- RST_N  in  1  asynchronous active-low reset
- frame_tick  in  1  one-CLK pulse per frame; the VGA driver's animate strobe, already edge-qualified
- btn_start  in  1  raw asynchronous start button, active-high
- game_over_evt  in  1  one-CLK pulse from game logic (lives exhausted)
- menu_rgb  in  12  menu screen colour {R,G,B}
- game_rgb  in  12  playfield colour
- over_rgb  in  12  game-over screen colour
- scene  out  2  0=MENU 1=START 2=PLAY 3=OVER
- game_rst  out  1  active-high reset to game logic
- blink_mask  out  1  1 = blank the game-over text region
- rgb_out  out  12  selected colour, registered

Behaviour:
Reset (RST_N low, asynchronous): all outputs, counters, pending flags and synchroniser flops go to zero, with two exceptions:
- scene=MENU.
- game_rst=1.

Button path:
- btn_start passes through a 2-FF synchroniser.
- A rising edge of the synchronised signal sets start_pend, but only while scene is MENU or OVER. Edges in START or PLAY are ignored.

Game-over event:
- game_over_evt sets over_pend only while scene=PLAY; it is ignored otherwise.

Pending flags:
- Both flags are cleared when the transition that consumes them fires.
- Both flags are cleared on any scene change.
- A set event and a clear in the same cycle: clear wins.

FSM:
- All transitions happen on a CLK edge where frame_tick=1. scene updates on that same edge, so it is visible the cycle after the tick.
- MENU: if start_pend -> START.
- START: unconditionally -> PLAY on the next frame_tick. START lasts exactly one full frame.
- PLAY: if over_pend -> OVER. On entry: blink_cnt=0, over_cnt=0, blink_mask=0 (text visible).
- OVER, on each frame_tick:
  - over_cnt increments.
  - blink_cnt increments. When blink_cnt==BLINK_FRAMES-1, blink_cnt wraps to 0 and blink_mask toggles.
  - If start_pend -> START.
  - Else if over_cnt==OVER_FRAMES-1 -> MENU.
  - If start_pend and timeout coincide on the same tick, start wins.

game_rst:
- Registered from the next-state value: 1 in MENU and START, 0 in PLAY and OVER.
- Falls on the same edge that scene becomes PLAY.

blink_mask:
- Forced 0 in every scene other than OVER.
- Cleared on exit from OVER.

Colour mux (one-cycle latency): rgb_out is registered from the current scene:
- MENU: menu_rgb
- START: 12'h000
- PLAY: game_rgb
- OVER: over_rgb

Counter widths:
- blink_cnt: $clog2(BLINK_FRAMES).
- over_cnt: $clog2(OVER_FRAMES).
- Neither counter overflows, because both are reset or wrapped before their terminal value.

Other boundary conditions:
- frame_tick held high for multiple cycles is outside the interface contract and need not be handled.
- Reset asserted mid-OVER returns to MENU immediately. No pending state survives reset.

Test Plan:
1. Reset release, no stimulus, 5 frame_ticks -> scene=0, game_rst=1, blink_mask=0, rgb_out=menu_rgb (e.g. 12'hABC).
2. btn_start pulse (>=3 CLK) mid-frame in MENU -> scene=1 the cycle after the next tick; scene=2 and game_rst=0 after the following tick; rgb_out=000 during START, then game_rgb.
3. PLAY with game_over_evt pulse -> scene=3 after the next tick. blink_mask=0 for 30 ticks, 1 for the next 30, then 0 again. rgb_out=over_rgb.
4. OVER, no button, OVER_FRAMES=300 -> scene returns to 0 after exactly 300 ticks from entry; game_rst=1 and blink_mask=0 in MENU.
5. OVER, btn_start edge arriving in the same frame the timeout tick fires -> scene=1 (START), not MENU. Also: game_over_evt pulsed in MENU or OVER -> no state change.
6. RST_N pulled low mid-OVER with blink_mask=1 -> scene=0, game_rst=1, blink_mask=0, rgb_out=0 asynchronously. A button press during reset does not cause a transition after release.

Source files
------------

// File: rtl/scene_sequencer.sv
// Screen ownership controller: sequences MENU/START/PLAY/OVER on frame ticks, gates the game
// logic reset, generates the game-over blink mask and registers the selected colour.
module scene_sequencer #(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned OVER_FRAMES  = 300
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        frame_tick,
  input  logic        btn_start,
  input  logic        game_over_evt,
  input  logic [11:0] menu_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] over_rgb,
  output logic [1:0]  scene,
  output logic        game_rst,
  output logic        blink_mask,
  output logic [11:0] rgb_out
);

  typedef enum logic [1:0] {
    StMenu  = 2'd0,
    StStart = 2'd1,
    StPlay  = 2'd2,
    StOver  = 2'd3
  } scene_e;

  // A single-frame blink period still needs a one-bit counter.
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned OverW  = $clog2(OVER_FRAMES);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [OverW-1:0]  OverLast  = OverW'(OVER_FRAMES - 1);

  scene_e             scene_q, scene_d;
  logic               btn_meta_q, btn_sync_q, btn_prev_q;
  logic               start_pend_q, start_pend_d;
  logic               over_pend_q, over_pend_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic [OverW-1:0]   over_cnt_q, over_cnt_d;
  logic               blink_q, blink_d;
  logic               game_rst_q;
  logic [11:0]        rgb_q;
  logic               btn_rise;
  logic               scene_change;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_meta_q <= btn_start;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
    end
  end

  assign btn_rise = btn_sync_q & ~btn_prev_q;

  always_comb begin
    scene_d     = scene_q;
    blink_cnt_d = blink_cnt_q;
    over_cnt_d  = over_cnt_q;
    blink_d     = blink_q;
    if (frame_tick) begin
      unique case (scene_q)
        StMenu:  if (start_pend_q) scene_d = StStart;
        StStart: scene_d = StPlay;
        StPlay:  if (over_pend_q) scene_d = StOver;
        StOver: begin
          over_cnt_d = over_cnt_q + 1'b1;
          if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
          // A pending start beats the timeout on the same tick.
          if (start_pend_q) begin
            scene_d = StStart;
          end else if (over_cnt_q == OverLast) begin
            scene_d = StMenu;
          end
        end
        default: scene_d = StMenu;
      endcase
    end
    // Counters and mask only live while staying in OVER; entry and exit both see them cleared.
    if (scene_d != StOver) begin
      blink_cnt_d = '0;
      over_cnt_d  = '0;
      blink_d     = 1'b0;
    end
  end

  assign scene_change = (scene_d != scene_q);

  always_comb begin
    start_pend_d = (start_pend_q | (btn_rise & ((scene_q == StMenu) | (scene_q == StOver))))
                   & ~scene_change;
    over_pend_d  = (over_pend_q | (game_over_evt & (scene_q == StPlay))) & ~scene_change;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scene_q      <= StMenu;
      start_pend_q <= 1'b0;
      over_pend_q  <= 1'b0;
      blink_cnt_q  <= '0;
      over_cnt_q   <= '0;
      blink_q      <= 1'b0;
      game_rst_q   <= 1'b1;
    end else begin
      scene_q      <= scene_d;
      start_pend_q <= start_pend_d;
      over_pend_q  <= over_pend_d;
      blink_cnt_q  <= blink_cnt_d;
      over_cnt_q   <= over_cnt_d;
      blink_q      <= blink_d;
      game_rst_q   <= (scene_d == StMenu) || (scene_d == StStart);
    end
  end

  // Colour follows the current scene with one cycle of latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rgb_q <= 12'h000;
    end else begin
      unique case (scene_q)
        StMenu:  rgb_q <= menu_rgb;
        StStart: rgb_q <= 12'h000;
        StPlay:  rgb_q <= game_rgb;
        StOver:  rgb_q <= over_rgb;
        default: rgb_q <= 12'h000;
      endcase
    end
  end

  assign scene      = scene_q;
  assign game_rst   = game_rst_q;
  assign blink_mask = blink_q;
  assign rgb_out    = rgb_q;

endmodule
